// File: rtl/adder16_pkg.sv
// Shared definitions for the serial digit adder: default operand geometry and FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder16_pkg;

    localparam int WIDTH_DEF = 16;  // operand width
    localparam int DIGIT_DEF = 4;   // bits summed per CALC cycle

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_digit.sv
// One digit slice of the serial adder: DIGIT-bit a + b + cin -> DIGIT-bit sum and carry-out.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b (DIGIT bits), cin -> sum (DIGIT bits), cout.
module adder_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    // One extra bit holds the carry-out of the digit.
    logic [DIGIT:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    assign sum  = full[DIGIT-1:0];
    assign cout = full[DIGIT];

endmodule

// File: rtl/adder16_serial_responder.sv
// Serial unsigned adder: accepts A/B in IDLE, sums DIGIT bits per cycle, presents C={carry,sum}.
// Latency: out_valid rises WIDTH/DIGIT edges after the accepting edge.
// Backpressure: C/out_valid hold in DONE until out_ready; in_ready is low from accept until after the result handshake.
// Ports: clk, reset (async, active-low); in_valid/in_ready + A/B request side;
//        out_valid/out_ready + C result side; busy (not IDLE); txn_count (completed handshakes, wraps).
// WIDTH must be a multiple of DIGIT and span at least two digits.
import adder16_pkg::*;

module adder16_serial_responder #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH:0]   C,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [15:0]      txn_count
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [DIGIT-1:0]   dsum;
    logic               dcout;
    logic               last_digit;

    adder_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (a_sh[DIGIT-1:0]),
        .b    (b_sh[DIGIT-1:0]),
        .cin  (carry),
        .sum  (dsum),
        .cout (dcout)
    );

    assign last_digit = (cnt == CNT_W'(NDIG - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = CALC;
            CALC:    if (last_digit) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Datapath: operands are only sampled in IDLE, so A/B activity during
    // CALC/DONE cannot disturb a result in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            txn_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        sum_sh <= '0;
                        carry  <= 1'b0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    // Digits enter from the top; after NDIG shifts the first
                    // (least significant) digit has reached bit 0.
                    sum_sh <= {dsum, sum_sh[WIDTH-1:DIGIT]};
                    carry  <= dcout;
                    cnt    <= cnt + 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        txn_count <= txn_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign C         = out_valid ? {carry, sum_sh} : '0;

endmodule

// File: tb/tb_adder16_serial_responder.sv
// Scoreboard bench for the serial adder: randomized and directed requests, decoupled monitor.
// Latency: n/a.
// Backpressure: out_ready driven fixed or randomized per phase.
module tb_adder16_serial_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic [16:0] C;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [15:0] txn_count;

    logic        rand_mode = 1'b0;
    logic        fixed_rdy = 1'b1;
    logic        rnd_rdy   = 1'b1;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    logic [16:0] sb_q[$];   // expected results in acceptance order
    int          lat_q[$];  // accepting-edge cycle numbers
    logic [15:0] exp_txn = '0;
    logic        pend    = 1'b0;
    logic        prev_ov = 1'b0;

    assign out_ready = rand_mode ? rnd_rdy : fixed_rdy;

    adder16_serial_responder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .C         (C),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rnd_rdy = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: all DUT outputs sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            sb_q.delete();
            lat_q.delete();
            exp_txn = '0;
            pend    = 1'b0;
            prev_ov = 1'b0;
        end else begin
            if (pend) begin
                check("txn_count", 32'(txn_count), 32'(exp_txn));
                pend = 1'b0;
            end
            check("busy_vs_ready", 32'(busy), 32'(!in_ready));
            if (!out_valid) begin
                check("c_zero_when_invalid", 32'(C), 32'd0);
            end else begin
                if (!prev_ov) begin
                    if (lat_q.size() == 0) fail_now("latency_no_accept");
                    else check("latency", 32'(cyc - lat_q.pop_front()), 32'd4);
                end
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    check("sum", 32'(C), 32'(sb_q[0]));
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                        exp_txn = exp_txn + 16'd1;
                        pend    = 1'b1;
                    end
                end
            end
            prev_ov = out_valid;
        end
    end

    // Present a request and wait (bounded) for it to be accepted.
    task automatic send(input logic [15:0] a, input logic [15:0] b, output int acc);
        int waited;
        @(posedge clk);
        #1;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        waited   = 0;
        acc      = -1;
        while (acc < 0) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc + 1;
            end else if (++waited > 200) begin
                fail_now("accept_timeout");
                break;
            end
        end
        if (acc >= 0) begin
            sb_q.push_back({1'b0, a} + {1'b0, b});
            lat_q.push_back(acc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A        = 16'($urandom);
        B        = 16'($urandom);
    endtask

    task automatic drain();
        int waited = 0;
        while (!(sb_q.size() == 0 && in_ready && !pend)) begin
            @(negedge clk);
            if (++waited > 500) begin
                fail_now("drain_timeout");
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, acc1, acc2, waited;
        logic [15:0] ra, rb;

        reset    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_c", 32'(C), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_txn", 32'(txn_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Basic 1+1
        send(16'h0001, 16'h0001, acc0);
        drain();
        check("basic_txn", 32'(txn_count), 32'd1);

        // Carry ripple
        send(16'hFFFF, 16'h0001, acc0);
        send(16'hFFFF, 16'hFFFF, acc0);
        drain();
        check("carry_txn", 32'(txn_count), 32'd3);

        // Backpressure: three DONE cycles held, handshake on the fourth
        #1 fixed_rdy = 1'b0;
        send(16'h1234, 16'h4321, acc0);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!out_valid && waited < 50);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_c", 32'(C), 32'h05555);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) fixed_rdy = 1'b1;
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_c", 32'(C), 32'h05555);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        check("bp_after_in_ready", 32'(in_ready), 32'd1);
        check("bp_after_valid", 32'(out_valid), 32'd0);
        check("bp_txn", 32'(txn_count), 32'd4);

        // Ignored input while CALC
        send(16'h0F0F, 16'h1111, acc0);
        in_valid = 1'b1;
        A        = 16'hAAAA;
        B        = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ign_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            A = 16'($urandom);
        end
        in_valid = 1'b0;
        drain();
        check("ign_txn", 32'(txn_count), 32'd5);

        // Throughput: three back-to-back requests
        send(16'h0102, 16'h0304, acc0);
        send(16'h8000, 16'h8000, acc1);
        send(16'h7FFF, 16'h0001, acc2);
        check("tput_gap01", 32'(acc1 - acc0), 32'd6);
        check("tput_gap12", 32'(acc2 - acc1), 32'd6);
        drain();
        check("tput_txn", 32'(txn_count), 32'd8);

        // Reset during the second CALC cycle
        send(16'h5555, 16'h1111, acc0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_c", 32'(C), 32'd0);
        check("mid_rst_txn", 32'(txn_count), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        send(16'h0003, 16'h0004, acc0);
        check("post_rst_first_accept", 32'(acc0), 32'(cyc));
        drain();
        check("post_rst_txn", 32'(txn_count), 32'd1);

        // Randomized phase with random backpressure
        rand_mode = 1'b1;
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 4))
                0:       begin ra = 16'hFFFF;         rb = 16'($urandom); end
                1:       begin ra = 16'($urandom);    rb = 16'hFFFF;      end
                default: begin ra = 16'($urandom);    rb = 16'($urandom); end
            endcase
            send(ra, rb, acc0);
        end
        drain();
        rand_mode = 1'b0;
        check("rand_txn", 32'(txn_count), 32'd26);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
